md_iter_unit: RTL and testbench
===============================

MD_ITER_UNIT -- requirements
Module: md_iter_unit

Interface
REQ-001 The block SHALL have the following ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- AE  input  32  operand A: multiplicand / dividend / mthi-mtlo write data.
- BE  input  32  operand B: multiplier / divisor.
- unsignE  input  1  1 = unsigned operation, 0 = signed two's complement.
- mulE  input  1  request multiply.
- divE  input  1  request divide.
- mthiE  input  1  write AE to HI.
- mtloE  input  1  write AE to LO.
- busy  output  1  operation in progress; the pipeline stalls any MD instruction while high.
- done  output  1  one-cycle pulse: new HI/LO visible.
- hi  output  32  HI register (product[63:32] / remainder).
- lo  output  32  LO register (product[31:0] / quotient).

Function
REQ-002 The state machine SHALL have three states: IDLE, CALC, FIX.
REQ-003 In IDLE with mulE=1 or divE=1, the rising edge SHALL latch operands, operation type and unsignE, and enter CALC with the iteration counter at 0.
REQ-004 If mulE and divE are both high, multiply SHALL take priority.
REQ-005 CALC SHALL run exactly 32 iterations, one per cycle, on operand magnitudes (absolute values when signed): shift-add multiply, or restoring radix-2 divide.
REQ-006 After iteration 31 the block SHALL enter FIX for one cycle, apply the sign correction, write HI/LO, then return to IDLE.
REQ-007 busy SHALL be high from the edge that accepts a request until the edge that leaves FIX: 33 cycles.
REQ-008 done SHALL be high for the single cycle after the FIX edge, i.e. the first cycle in which the updated hi/lo are observable.
REQ-009 Multiply results: signed gives the 64-bit two's-complement product; unsigned gives the 64-bit unsigned product; HI=[63:32], LO=[31:0].
REQ-010 Divide results: quotient in LO, truncated toward zero; remainder in HI, with the sign of the dividend.
REQ-011 Divide by zero (BE=0), signed or unsigned: HI=AE, LO=32'hFFFFFFFF, with the same 33-cycle latency.
REQ-012 Signed 32'h80000000 / 32'hFFFFFFFF SHALL produce LO=32'h80000000 and HI=0.
REQ-013 mthiE/mtloE in IDLE SHALL write AE to HI/LO at the next edge; both high writes both registers; done is not asserted.
REQ-014 In IDLE, a start (mulE/divE) in the same cycle as mthiE/mtloE SHALL win; the mthi/mtlo is discarded.
REQ-015 While busy, all of mulE, divE, mthiE and mtloE SHALL be ignored; HI/LO are unchanged until FIX.
REQ-016 hi and lo SHALL be driven directly from registers, with no combinational path from the inputs.

Reset
REQ-017 Asserting reset SHALL immediately force: state=IDLE, hi=0, lo=0, busy=0, done=0, and the iteration counter and datapath registers to 0.
REQ-018 Reset during CALC or FIX SHALL abort the operation; no partial result reaches HI/LO.
REQ-019 The first request after reset deasserts SHALL be accepted normally on the next edge.

Verification
REQ-020 Signed mult, AE=32'hFFFFFFFD (-3), BE=5, unsignE=0 -> busy high 33 cycles, then done pulse; HI=32'hFFFFFFFF, LO=32'hFFFFFFF1.
REQ-021 Unsigned mult, AE=BE=32'hFFFFFFFF, unsignE=1 -> HI=32'hFFFFFFFE, LO=32'h00000001.
REQ-022 Signed div, AE=32'hFFFFFFF9 (-7), BE=2 -> LO=32'hFFFFFFFD, HI=32'hFFFFFFFF; repeat with unsignE=1 -> LO=32'h7FFFFFFC, HI=1.
REQ-023 Div by zero, AE=32'h12345678, BE=0 -> HI=32'h12345678, LO=32'hFFFFFFFF; then signed 32'h80000000 / 32'hFFFFFFFF -> LO=32'h80000000, HI=0.
REQ-024 mthiE with AE=32'hA5A5A5A5 in IDLE -> hi=32'hA5A5A5A5 next cycle, no done pulse; start a multiply, pulse mtloE mid-CALC -> ignored, LO ends as the product.
REQ-025 Start a divide, assert reset at iteration 10 -> busy=0 and hi=lo=0 immediately; a new mult 3*4 -> HI=0, LO=12 after 33 cycles.

Source files
------------

// File: rtl/md_iter_unit.sv
// rtl/md_iter_unit.sv - iterative 32x32 multiply / divide unit with HI/LO registers
module md_iter_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] AE,
    input  logic [31:0] BE,
    input  logic        unsignE,
    input  logic        mulE,
    input  logic        divE,
    input  logic        mthiE,
    input  logic        mtloE,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t      state, state_next;
    logic [4:0]  cnt;
    logic        op_div, op_uns;
    logic [31:0] a_reg, b_reg;
    logic [31:0] upper, lower;

    logic        start;
    logic [31:0] in_a_mag, in_b_mag;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag;
    logic [32:0] mul_sum;
    logic [32:0] div_shift;
    logic        div_ok;
    logic [31:0] div_rem;
    logic [63:0] prod_fix;
    logic [31:0] quo_fix, rem_fix;

    assign start    = mulE | divE;
    assign in_a_mag = (!unsignE && AE[31]) ? (32'd0 - AE) : AE;
    assign in_b_mag = (!unsignE && BE[31]) ? (32'd0 - BE) : BE;

    // Sign flags and magnitudes of the latched operands
    assign a_neg = ~op_uns & a_reg[31];
    assign b_neg = ~op_uns & b_reg[31];
    assign a_mag = a_neg ? (32'd0 - a_reg) : a_reg;
    assign b_mag = b_neg ? (32'd0 - b_reg) : b_reg;

    // One shift-add step: {upper,lower} holds partial product over remaining multiplier bits
    assign mul_sum = {1'b0, upper} + (lower[0] ? {1'b0, a_mag} : 33'd0);

    // One restoring-divide step: upper is the partial remainder, lower shifts dividend out / quotient in
    assign div_shift = {upper, lower[31]};
    assign div_ok    = (div_shift >= {1'b0, b_mag});
    assign div_rem   = div_ok ? 32'(div_shift - {1'b0, b_mag}) : div_shift[31:0];

    // Sign correction applied in FIX
    assign prod_fix = (a_neg ^ b_neg) ? (64'd0 - {upper, lower}) : {upper, lower};
    assign quo_fix  = (a_neg ^ b_neg) ? (32'd0 - lower) : lower;
    assign rem_fix  = a_neg ? (32'd0 - upper) : upper;

    assign busy = (state != IDLE);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = CALC;
            CALC:    if (cnt == 5'd31) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath, iteration counter and HI/LO registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt    <= 5'd0;
            op_div <= 1'b0;
            op_uns <= 1'b0;
            a_reg  <= 32'd0;
            b_reg  <= 32'd0;
            upper  <= 32'd0;
            lower  <= 32'd0;
            hi     <= 32'd0;
            lo     <= 32'd0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg  <= AE;
                        b_reg  <= BE;
                        op_div <= ~mulE;
                        op_uns <= unsignE;
                        cnt    <= 5'd0;
                        upper  <= 32'd0;
                        lower  <= mulE ? in_b_mag : in_a_mag;
                    end else begin
                        if (mthiE) hi <= AE;
                        if (mtloE) lo <= AE;
                    end
                end
                CALC: begin
                    cnt <= cnt + 5'd1;
                    if (op_div) begin
                        upper <= div_rem;
                        lower <= {lower[30:0], div_ok};
                    end else begin
                        upper <= mul_sum[32:1];
                        lower <= {mul_sum[0], lower[31:1]};
                    end
                end
                FIX: begin
                    done <= 1'b1;
                    if (!op_div) begin
                        hi <= prod_fix[63:32];
                        lo <= prod_fix[31:0];
                    end else if (b_reg == 32'd0) begin
                        hi <= a_reg;
                        lo <= 32'hFFFFFFFF;
                    end else begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_md_iter_unit.sv
// tb/tb_md_iter_unit.sv - self-checking bench for md_iter_unit
module tb_md_iter_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] AE = '0, BE = '0;
    logic        unsignE = 1'b0, mulE = 1'b0, divE = 1'b0, mthiE = 1'b0, mtloE = 1'b0;
    logic        busy, done;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;

    md_iter_unit dut (
        .clk(clk), .reset(reset), .AE(AE), .BE(BE), .unsignE(unsignE),
        .mulE(mulE), .divE(divE), .mthiE(mthiE), .mtloE(mtloE),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference arithmetic from the architectural definition of MULT/DIV
    function automatic void compute(input logic [31:0] a, input logic [31:0] b,
                                    input bit u, input bit m,
                                    output logic [31:0] h, output logic [31:0] l);
        longint sa, sb, p, q, r;
        if (u) begin
            sa = {32'd0, a};
            sb = {32'd0, b};
        end else begin
            sa = {{32{a[31]}}, a};
            sb = {{32{b[31]}}, b};
        end
        if (m) begin
            p = sa * sb;
            h = p[63:32];
            l = p[31:0];
        end else if (b == 32'd0) begin
            h = a;
            l = 32'hFFFFFFFF;
        end else begin
            q = sa / sb;
            r = sa % sb;
            h = r[31:0];
            l = q[31:0];
        end
    endfunction

    // Transaction-level model: a request occupies the unit for 33 cycles, then results land
    int          rem_cycles = 0;
    logic [31:0] m_hi = '0, m_lo = '0, pend_hi = '0, pend_lo = '0;
    bit          m_done = 1'b0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            rem_cycles = 0;
            m_hi = '0;
            m_lo = '0;
            m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (rem_cycles > 0) begin
                rem_cycles--;
                if (rem_cycles == 0) begin
                    m_hi = pend_hi;
                    m_lo = pend_lo;
                    m_done = 1'b1;
                end
            end else if (mulE || divE) begin
                compute(AE, BE, unsignE, mulE, pend_hi, pend_lo);
                rem_cycles = 33;
            end else begin
                if (mthiE) m_hi = AE;
                if (mtloE) m_lo = AE;
            end
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        chk("cmp_busy", {31'd0, busy}, {31'd0, rem_cycles > 0});
        chk("cmp_done", {31'd0, done}, {31'd0, m_done});
        chk("cmp_hi", hi, m_hi);
        chk("cmp_lo", lo, m_lo);
    end

    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input bit u,
                            input bit m, input bit d, input bit mh, input bit ml);
        @(negedge clk);
        AE = a; BE = b; unsignE = u; mulE = m; divE = d; mthiE = mh; mtloE = ml;
        @(negedge clk);
        mulE = 1'b0; divE = 1'b0; mthiE = 1'b0; mtloE = 1'b0;
    endtask

    task automatic finish_op(input string nm, input logic [31:0] eh, input logic [31:0] el,
                             input bit check_bc);
        int bc;
        bit got;
        bc = 0;
        got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            if (done) got = 1'b1;
            else begin
                if (busy) bc++;
                @(negedge clk);
            end
        end
        chk({nm, "_done_seen"}, {31'd0, got}, 32'd1);
        if (check_bc) chk({nm, "_busy_cycles"}, bc, 32'd33);
        chk({nm, "_hi"}, hi, eh);
        chk({nm, "_lo"}, lo, el);
    endtask

    task automatic do_op(input string nm, input logic [31:0] a, input logic [31:0] b,
                         input bit u, input bit m, input bit d,
                         input logic [31:0] eh, input logic [31:0] el);
        start_op(a, b, u, m, d, 1'b0, 1'b0);
        finish_op(nm, eh, el, 1'b1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        reset = 1'b0;

        do_op("smul_m3x5", 32'hFFFFFFFD, 32'd5, 1'b0, 1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFF1);
        do_op("umul_max", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0, 32'hFFFFFFFE, 32'h00000001);
        do_op("sdiv_m7_2", 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFD);
        do_op("udiv_m7_2", 32'hFFFFFFF9, 32'd2, 1'b1, 1'b0, 1'b1, 32'h00000001, 32'h7FFFFFFC);
        do_op("div_zero", 32'h12345678, 32'd0, 1'b0, 1'b0, 1'b1, 32'h12345678, 32'hFFFFFFFF);
        do_op("udiv_zero", 32'h87654321, 32'd0, 1'b1, 1'b0, 1'b1, 32'h87654321, 32'hFFFFFFFF);
        do_op("sdiv_ovf", 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 32'h00000000, 32'h80000000);
        do_op("sdiv_7_m2", 32'd7, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b1, 32'h00000001, 32'hFFFFFFFD);
        do_op("smul_neg_neg", 32'h80000000, 32'h80000000, 1'b0, 1'b1, 1'b0, 32'h40000000, 32'h00000000);
        do_op("mul_div_prio", 32'd6, 32'd7, 1'b0, 1'b1, 1'b1, 32'h00000000, 32'd42);

        // mthi in idle, no done
        @(negedge clk);
        AE = 32'hA5A5A5A5; mthiE = 1'b1;
        @(negedge clk);
        mthiE = 1'b0;
        chk("mthi_hi", hi, 32'hA5A5A5A5);
        chk("mthi_no_done", {31'd0, done}, 32'd0);

        // mthi + mtlo together
        @(negedge clk);
        AE = 32'h11223344; mthiE = 1'b1; mtloE = 1'b1;
        @(negedge clk);
        mthiE = 1'b0; mtloE = 1'b0;
        chk("mthilo_hi", hi, 32'h11223344);
        chk("mthilo_lo", lo, 32'h11223344);

        // start in same cycle as mthi: mthi discarded
        start_op(32'd2, 32'd3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        finish_op("start_wins", 32'd0, 32'd6, 1'b1);

        // mtlo pulsed mid-CALC is ignored
        start_op(32'd7, 32'd9, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        AE = 32'hDEADBEEF; mtloE = 1'b1; mthiE = 1'b1; divE = 1'b1;
        @(negedge clk);
        mtloE = 1'b0; mthiE = 1'b0; divE = 1'b0;
        finish_op("mtlo_busy", 32'd0, 32'd63, 1'b0);

        // reset during divide at iteration 10
        start_op(32'd1000, 32'd7, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (9) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_hi", hi, 32'd0);
        chk("abort_lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        do_op("post_reset_3x4", 32'd3, 32'd4, 1'b0, 1'b1, 1'b0, 32'd0, 32'd12);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

endmodule
